// File: rtl/usart_tx_pkg.sv
// Shared types and constants for the usart_tx transmitter.
// The PARITY state exists only when USART_TX_PARITY_EN is defined.
package usart_tx_pkg;

    localparam int DATA_BITS      = 8;
    localparam int FRAME_BITS_8N1 = 10;
    localparam int FRAME_BITS_8E1 = 11;

`ifdef USART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;
    localparam int FRAME_BITS = FRAME_BITS_8E1;
`else
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;
    localparam int FRAME_BITS = FRAME_BITS_8N1;
`endif

    // Rounded clock cycles per line bit.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/usart_tx_baud_gen.sv
// Bit-period timer: pulses tick_o for one cycle every DIV cycles while enabled.
module usart_tx_baud_gen #(
    parameter int DIV = 139
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Reloads at every bit boundary so each bit lasts exactly DIV cycles.
    always_comb begin
        tick_o = en_i && (cnt_q == CNT_W'(DIV - 1));
        cnt_d  = cnt_q + CNT_W'(1);
        if (!en_i || restart_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/usart_tx.sv
// Asynchronous serial transmitter, 8N1 by default; 8E1 with USART_TX_PARITY_EN defined.
// tx comes straight from a flop so the line never glitches.
module usart_tx
    import usart_tx_pkg::*;
#(
    parameter int fsm_clk_freq = 16000000,
    parameter int baud_rate    = 115200
) (
    input  logic       clk,
    input  logic       reset,
    output logic       tx_led,
    input  logic [7:0] bytetosend,
    input  logic       send,
    output logic       sent,
    output logic       tx
);

    localparam int DIV = calc_div(fsm_clk_freq, baud_rate);

    state_t               state_q, state_d;
    logic                 tx_q, tx_d;
    logic                 sent_q, sent_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           idx_q, idx_d;
    logic                 tick;
    logic                 start;
`ifdef USART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    assign start = (state_q == IDLE) && send;

    usart_tx_baud_gen #(
        .DIV(DIV)
    ) u_baud_gen (
        .clk      (clk),
        .reset    (reset),
        .en_i     (state_q != IDLE),
        .restart_i(start),
        .tick_o   (tick)
    );

    // The byte is captured on the start edge; later bytetosend changes are ignored.
    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        sent_d   = sent_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
`ifdef USART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (send) begin
                    state_d  = START;
                    tx_d     = 1'b0;
                    sent_d   = 1'b0;
                    shift_d  = bytetosend;
                    idx_d    = '0;
`ifdef USART_TX_PARITY_EN
                    parity_d = ^bytetosend;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef USART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef USART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    sent_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                sent_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            tx_q     <= 1'b1;
            sent_q   <= 1'b1;
            shift_q  <= '0;
            idx_q    <= '0;
`ifdef USART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            sent_q   <= sent_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
`ifdef USART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx     = tx_q;
    assign sent   = sent_q;
    assign tx_led = ~sent_q;

endmodule

// File: tb/tb_usart_tx.sv
// Bench for usart_tx: a line monitor decodes every frame and checks it against a scoreboard queue.
`timescale 1ns/1ps
module tb_usart_tx;

    localparam int DIV = 139;
`ifdef USART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYCLES = FRAME_BITS * DIV;

    typedef struct {
        logic [7:0] data;
        logic       parity;
    } frame_t;

    typedef struct {
        logic [7:0] data;
        logic       parity;
        int         idleAfter;
    } vector_t;

    logic       clk;
    logic       rstN;
    logic [7:0] byteToSend;
    logic       send;
    logic       sent;
    logic       tx;
    logic       txLed;

    int errors = 0;
    int checks = 0;
    int startCount = 0;
    int doneCount = 0;
    int lastGap = 0;
    int ledBad = 0;
    int idleTxBad = 0;

    frame_t  sbQueue[$];
    vector_t vectors[6];

    usart_tx #(
        .fsm_clk_freq(16000000),
        .baud_rate   (115200)
    ) dut (
        .clk       (clk),
        .reset     (rstN),
        .tx_led    (txLed),
        .bytetosend(byteToSend),
        .send      (send),
        .sent      (sent),
        .tx        (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic parity);
        frame_t f;
        @(negedge clk);
        byteToSend = data;
        send       = 1'b1;
        f.data     = data;
        f.parity   = parity;
        sbQueue.push_back(f);
        @(negedge clk);
        send       = 1'b0;
        byteToSend = 8'($urandom);
    endtask

    task automatic waitFrames(input int target, input int budget);
        int n = 0;
        while (doneCount < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #2;
        checkOutput("frame completion", 32'(doneCount >= target), 32'd1);
    endtask

    // Line monitor: samples 1ns after each rising edge and decodes one frame per sent-low window.
    initial begin : monitor
        logic [FRAME_BITS-1:0] lineBits;
        logic   unstable, earlySent, aborted;
        frame_t exp;
        int     idleRun;
        idleRun = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rstN) begin
                idleRun = 0;
            end else if (sent === 1'b1) begin
                idleRun++;
                if (tx !== 1'b1) idleTxBad++;
                if (txLed !== ~sent) ledBad++;
            end else begin
                lastGap = idleRun;
                startCount++;
                unstable  = 1'b0;
                earlySent = 1'b0;
                aborted   = 1'b0;
                lineBits  = '0;
                for (int b = 0; b < FRAME_BITS && !aborted; b++) begin
                    for (int c = 0; c < DIV && !aborted; c++) begin
                        if (b != 0 || c != 0) begin
                            @(posedge clk);
                            #1;
                        end
                        if (!rstN) begin
                            aborted = 1'b1;
                        end else begin
                            if (c == 0) lineBits[b] = tx;
                            else if (tx !== lineBits[b]) unstable = 1'b1;
                            if (sent !== 1'b0) earlySent = 1'b1;
                            if (txLed !== ~sent) ledBad++;
                        end
                    end
                end
                idleRun = 0;
                if (!aborted) begin
                    @(posedge clk);
                    #1;
                    if (rstN) begin
                        checkOutput("sent low duration", {30'd0, earlySent, sent}, 32'd1);
                        checkOutput("start bit", 32'(lineBits[0]), 32'd0);
                        checkOutput("stop bit", 32'(lineBits[FRAME_BITS-1]), 32'd1);
                        checkOutput("bit stability", 32'(unstable), 32'd0);
                        checkOutput("frame expected", 32'(sbQueue.size() > 0), 32'd1);
                        if (sbQueue.size() > 0) begin
                            exp = sbQueue.pop_front();
                            checkOutput("data bits", 32'(lineBits[8:1]), 32'(exp.data));
`ifdef USART_TX_PARITY_EN
                            checkOutput("parity bit", 32'(lineBits[9]), 32'(exp.parity));
`endif
                        end
                        if (txLed !== ~sent) ledBad++;
                        idleRun = (sent === 1'b1) ? 1 : 0;
                    end
                    doneCount++;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int s0;
        int d0;
        rstN       = 1'b0;
        send       = 1'b0;
        byteToSend = 8'h00;

        vectors[0] = '{8'h55, 1'b0, 0};
        vectors[1] = '{8'hA3, 1'b0, 2000};
        vectors[2] = '{8'h07, 1'b1, 0};
        vectors[3] = '{8'h00, 1'b0, 0};
        vectors[4] = '{8'h80, 1'b1, 0};
        vectors[5] = '{8'hFF, 1'b0, 0};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset tx", 32'(tx), 32'd1);
        checkOutput("reset sent", 32'(sent), 32'd1);
        checkOutput("reset tx_led", 32'(txLed), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("idle after release tx", 32'(tx), 32'd1);
        checkOutput("idle after release sent", 32'(sent), 32'd1);
        checkOutput("no frame without send", 32'(startCount), 32'd0);

        // Table vectors, with bytetosend scrambled while each frame is on the line.
        for (int i = 0; i < 6; i++) begin
            d0 = doneCount;
            applyStimulus(vectors[i].data, vectors[i].parity);
            repeat (5) begin
                repeat (200) @(negedge clk);
                byteToSend = 8'($urandom);
            end
            waitFrames(d0 + 1, 2 * FRAME_CYCLES);
            if (vectors[i].idleAfter > 0) begin
                s0 = startCount;
                repeat (vectors[i].idleAfter) @(posedge clk);
                #1;
                checkOutput("long idle tx", 32'(tx), 32'd1);
                checkOutput("long idle sent", 32'(sent), 32'd1);
                checkOutput("long idle no frame", 32'(startCount), 32'(s0));
            end
        end

        // A second request while busy must be dropped.
        s0 = startCount;
        d0 = doneCount;
        applyStimulus(8'h01, 1'b1);
        repeat (499) @(negedge clk);
        byteToSend = 8'hFF;
        send       = 1'b1;
        @(negedge clk);
        send       = 1'b0;
        waitFrames(d0 + 1, 2 * FRAME_CYCLES);
        repeat (300) @(posedge clk);
        #1;
        checkOutput("busy request ignored", 32'(startCount), 32'(s0 + 1));

        // send held high: two frames back to back, one idle cycle between them.
        s0 = startCount;
        d0 = doneCount;
        @(negedge clk);
        byteToSend = 8'h0F;
        send       = 1'b1;
        sbQueue.push_back('{8'h0F, 1'b0});
        sbQueue.push_back('{8'h0F, 1'b0});
        repeat (2000) @(negedge clk);
        send = 1'b0;
        waitFrames(d0 + 2, 2 * FRAME_CYCLES);
        checkOutput("back-to-back gap", 32'(lastGap), 32'd1);
        repeat (100) @(posedge clk);
        #1;
        checkOutput("held send frame count", 32'(startCount), 32'(s0 + 2));

        // Asynchronous reset in the middle of a data bit that is 0 on the line.
        s0 = startCount;
        d0 = doneCount;
        @(negedge clk);
        byteToSend = 8'hC3;
        send       = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (700) @(posedge clk);
        #1;
        checkOutput("pre-reset tx", 32'(tx), 32'd0);
        checkOutput("pre-reset sent", 32'(sent), 32'd0);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("async reset tx", 32'(tx), 32'd1);
        checkOutput("async reset sent", 32'(sent), 32'd1);
        checkOutput("async reset tx_led", 32'(txLed), 32'd0);
        repeat (5) @(negedge clk);
        rstN = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        checkOutput("post-reset no frame", 32'(startCount), 32'(s0 + 1));
        checkOutput("aborted frame not completed", 32'(doneCount), 32'(d0));
        checkOutput("post-reset tx", 32'(tx), 32'd1);

        d0 = doneCount;
        applyStimulus(8'h5A, 1'b0);
        waitFrames(d0 + 1, 2 * FRAME_CYCLES);

        repeat (20) @(posedge clk);
        #1;
        checkOutput("tx_led tracks ~sent", 32'(ledBad), 32'd0);
        checkOutput("idle line high", 32'(idleTxBad), 32'd0);
        checkOutput("scoreboard drained", 32'(sbQueue.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
